layer_compositor: RTL

//   Parametrised per-pixel layer compositor.
//   - Takes NUM_LAYERS hit flags from the region/sprite detectors.
//   - Qualifies them with a per-frame enable mask and a per-layer blink mode.
//   - Selects the highest-priority visible layer and emits its colour-palette code.
//   - Sits between the region detectors and the palette/VGA output stage.
//   - Delays sync alongside the pixel so output timing stays aligned.

---
 rtl/layer_compositor.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/layer_compositor.sv
// layer_compositor: per-pixel layer compositor.
// Qualifies layer hit flags with a frame-latched enable mask and blink
// mode, picks the highest-priority (lowest index) visible layer and emits
// its palette code. Sync travels alongside the pixel so the output stays
// aligned with the two-stage pipeline.
//
// Flow control: there is no handshake. pix_valid marks an active-video
// pixel and one pixel is accepted every clock with no backpressure;
// out_valid is pix_valid delayed by exactly two cycles.
module layer_compositor #(
    parameter int NUM_LAYERS = 8,
    parameter int CODE_W     = 5,
    parameter int SYNC_W     = 2,
    parameter int BLINK_LOG2 = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         frame_start,
    input  logic                         pix_valid,
    input  logic [NUM_LAYERS-1:0]        hit,
    input  logic [SYNC_W-1:0]            sync_in,
    input  logic [NUM_LAYERS-1:0]        cfg_mask,
    input  logic [NUM_LAYERS-1:0]        cfg_blink,
    input  logic [NUM_LAYERS*CODE_W-1:0] cfg_codes,
    input  logic [CODE_W-1:0]            bg_code,
    output logic                         out_valid,
    output logic [CODE_W-1:0]            display,
    output logic                         out_hit,
    output logic [SYNC_W-1:0]            sync_out
);

    // Layer index width; a single-layer build still needs a 1-bit index.
    localparam int IDX_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam int FC_W  = BLINK_LOG2 + 1;

    // Active (frame-latched) configuration.
    logic [NUM_LAYERS-1:0]        r_mask;
    logic [NUM_LAYERS-1:0]        r_blink;
    logic [NUM_LAYERS*CODE_W-1:0] r_codes;
    logic [CODE_W-1:0]            r_bg;
    logic [FC_W-1:0]              r_frame_cnt;

    // Stage 1 registers: qualified hits plus a snapshot of the codes that
    // were active when the pixel was presented.
    logic                         r_s1_valid;
    logic [NUM_LAYERS-1:0]        r_s1_q;
    logic [NUM_LAYERS*CODE_W-1:0] r_s1_codes;
    logic [CODE_W-1:0]            r_s1_bg;
    logic [SYNC_W-1:0]            r_s1_sync;

    // Stage 2 (output) registers.
    logic                         r_out_valid;
    logic [CODE_W-1:0]            r_display;
    logic                         r_out_hit;
    logic [SYNC_W-1:0]            r_sync_out;

    // Combinational helpers.
    logic                         w_phase;
    logic [NUM_LAYERS-1:0]        w_q;
    logic                         w_any;
    logic [IDX_W-1:0]             w_win_idx;
    logic [CODE_W-1:0]            w_win_code;

    // Blink phase comes from the top bit of the frame counter; blinking
    // layers are hidden while it is set.
    assign w_phase = r_frame_cnt[BLINK_LOG2];
    assign w_q     = hit & r_mask & ~(r_blink & {NUM_LAYERS{w_phase}});

    // Latch configuration and advance the blink counter on frame_start only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mask      <= '0;
            r_blink     <= '0;
            r_codes     <= '0;
            r_bg        <= '0;
            r_frame_cnt <= '0;
        end else if (frame_start) begin
            r_mask      <= cfg_mask;
            r_blink     <= cfg_blink;
            r_codes     <= cfg_codes;
            r_bg        <= bg_code;
            r_frame_cnt <= r_frame_cnt + FC_W'(1);
        end
    end

    // Stage 1: qualify against the config present this cycle and freeze
    // the codes with the pixel, so a later frame_start cannot touch it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_q     <= '0;
            r_s1_codes <= '0;
            r_s1_bg    <= '0;
            r_s1_sync  <= '0;
        end else begin
            r_s1_valid <= pix_valid;
            r_s1_q     <= pix_valid ? w_q : '0;
            r_s1_codes <= r_codes;
            r_s1_bg    <= r_bg;
            r_s1_sync  <= sync_in;
        end
    end

    // Priority encoder: scan from the highest index down so the lowest
    // qualified index is the final assignment.
    always_comb begin
        w_any     = 1'b0;
        w_win_idx = '0;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (r_s1_q[i]) begin
                w_any     = 1'b1;
                w_win_idx = IDX_W'(i);
            end
        end
    end

    assign w_win_code = r_s1_codes[w_win_idx*CODE_W +: CODE_W];

    // Stage 2: choose winner code or background; blank invalid pixels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_display   <= '0;
            r_out_hit   <= 1'b0;
            r_sync_out  <= '0;
        end else begin
            r_out_valid <= r_s1_valid;
            r_sync_out  <= r_s1_sync;
            if (!r_s1_valid) begin
                r_display <= '0;
                r_out_hit <= 1'b0;
            end else if (w_any) begin
                r_display <= w_win_code;
                r_out_hit <= 1'b1;
            end else begin
                r_display <= r_s1_bg;
                r_out_hit <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign display   = r_display;
    assign out_hit   = r_out_hit;
    assign sync_out  = r_sync_out;

endmodule
